template_match_scan: RTL and testbench

- Binary template matcher for the camera pipeline.
- On `start`, loads a TEMPL_W x TEMPL_H 1-bit template from SRAM, then scans the 1-bit image held in the same SRAM.
- At each candidate window it accumulates the Hamming distance (XOR + popcount). It reports the lowest-distance window position and whether that distance meets a runtime threshold.
- Sits between the SRAM read mux and the display/overlay logic.
- Generalises fixed-size template loading to parametrised template/image geometry, memory latency and vertical stride, and adds actual scoring.

---
 rtl/tm_scan_pkg.sv | 36 +++
 rtl/tm_popcount16.sv | 14 +
 rtl/template_match_scan.sv | 233 +++++++++++++++++++++++
 tb/tb_template_match_scan.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tm_scan_pkg.sv
// Shared types and geometry helpers for the binary template matcher.
package tm_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_TEMPL,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_e;

    function automatic int tw_words(input int templ_w);
        return templ_w / 16;
    endfunction

    function automatic int img_words(input int img_w);
        return img_w / 16;
    endfunction

    function automatic int score_w(input int templ_w, input int templ_h);
        return $clog2(templ_w * templ_h + 1);
    endfunction

    function automatic int n_win(input int templ_w, input int templ_h,
                                 input int img_w, input int img_h, input int stride_y);
        return (img_w / 16 - templ_w / 16 + 1) * ((img_h - templ_h) / stride_y + 1);
    endfunction

    // Word address of template word (r, c) of the window at (y, xw).
    function automatic logic [19:0] img_addr(input logic [19:0] base, input int words,
                                             input logic [8:0] y, input logic [8:0] r,
                                             input logic [5:0] xw, input logic [5:0] c);
        return 20'(32'(base) + (32'(y) + 32'(r)) * 32'(words) + 32'(xw) + 32'(c));
    endfunction

endpackage

// File: rtl/tm_popcount16.sv
// Combinational population count of one 16-pixel word.
module tm_popcount16 (
    input  logic [15:0] data_i,
    output logic [4:0]  count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < 16; i++) begin
            count_o = count_o + {4'b0, data_i[i]};
        end
    end

endmodule

// File: rtl/template_match_scan.sv
// Loads a 1-bit template from SRAM, then slides it over the image and
// reports the window with the lowest Hamming distance.
module template_match_scan
    import tm_scan_pkg::*;
#(
    parameter int          TEMPL_W    = 64,
    parameter int          TEMPL_H    = 64,
    parameter int          IMG_W      = 640,
    parameter int          IMG_H      = 480,
    parameter logic [19:0] TEMPL_BASE = 20'h40000,
    parameter logic [19:0] IMG_BASE   = 20'h0,
    parameter int          MEM_LAT    = 1,
    parameter int          STRIDE_Y   = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 start_i,
    input  logic [score_w(TEMPL_W, TEMPL_H)-1:0] thresh_i,
    input  logic [15:0]                          mem_data_i,
    output logic [19:0]                          mem_addr_o,
    output logic                                 mem_rd_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [9:0]                           best_x_o,
    output logic [8:0]                           best_y_o,
    output logic [score_w(TEMPL_W, TEMPL_H)-1:0] best_score_o,
    output logic                                 match_o
);

    localparam int TW_WORDS  = tw_words(TEMPL_W);
    localparam int IMG_WORDS = img_words(IMG_W);
    localparam int SW        = score_w(TEMPL_W, TEMPL_H);
    localparam int NT        = TW_WORDS * TEMPL_H;
    localparam int IW        = (NT > 1) ? $clog2(NT) : 1;

    localparam logic [5:0] C_MAX  = 6'(TW_WORDS - 1);
    localparam logic [5:0] XW_MAX = 6'(IMG_WORDS - TW_WORDS);
    localparam logic [8:0] R_MAX  = 9'(TEMPL_H - 1);
    localparam logic [8:0] Y_MAX  = 9'(((IMG_H - TEMPL_H) / STRIDE_Y) * STRIDE_Y);
    localparam logic [8:0] Y_STEP = 9'(STRIDE_Y);

    if (TEMPL_W % 16 != 0 || IMG_W % 16 != 0 || TEMPL_W < 16 || TEMPL_W > IMG_W ||
        TEMPL_H < 1 || TEMPL_H > IMG_H || IMG_W > 1024 || IMG_H > 512 ||
        MEM_LAT < 1 || MEM_LAT > 4 || STRIDE_Y < 1 ||
        32'(IMG_BASE) + 32'(IMG_WORDS * IMG_H) > 32'h100000 ||
        32'(TEMPL_BASE) + 32'(NT) > 32'h100000) begin : g_bad_param
        $error("template_match_scan: illegal parameter set");
    end

    state_e          state_q, state_d;
    logic [SW-1:0]   thresh_q, thresh_d;
    logic [SW-1:0]   best_score_q, best_score_d;
    logic [9:0]      best_x_q, best_x_d;
    logic [8:0]      best_y_q, best_y_d;
    logic            match_q, match_d;
    logic [SW-1:0]   acc_q, acc_d;
    logic [5:0]      c_q, c_d, xw_q, xw_d;
    logic [8:0]      r_q, r_d, y_q, y_d;
    logic            ld_issued_q, ld_issued_d;

    logic [NT-1:0][15:0] templ_q;

    // Return tagging: stage MEM_LAT-1 lines up with the word on mem_data_i.
    logic [MEM_LAT-1:0]         vld_pipe_q, fin_pipe_q, wl_pipe_q;
    logic [MEM_LAT-1:0][IW-1:0] idx_pipe_q;
    logic [MEM_LAT-1:0][5:0]    xw_pipe_q;
    logic [MEM_LAT-1:0][8:0]    y_pipe_q;

    logic          mem_rd, iss_fin, iss_wl;
    logic [19:0]   mem_addr;
    logic [IW-1:0] iss_idx;

    wire           ret_vld = vld_pipe_q[MEM_LAT-1];
    wire           ret_fin = fin_pipe_q[MEM_LAT-1];
    wire           ret_wl  = wl_pipe_q[MEM_LAT-1];
    wire  [IW-1:0] ret_idx = idx_pipe_q[MEM_LAT-1];
    wire  [5:0]    ret_xw  = xw_pipe_q[MEM_LAT-1];
    wire  [8:0]    ret_y   = y_pipe_q[MEM_LAT-1];

    logic [4:0]    pop;
    logic [SW-1:0] sum;

    tm_popcount16 u_pop (
        .data_i  (mem_data_i ^ templ_q[ret_idx]),
        .count_o (pop)
    );

    assign sum = acc_q + SW'(pop);

    always_comb begin
        state_d      = state_q;
        thresh_d     = thresh_q;
        best_score_d = best_score_q;
        best_x_d     = best_x_q;
        best_y_d     = best_y_q;
        match_d      = match_q;
        acc_d        = acc_q;
        c_d          = c_q;
        r_d          = r_q;
        xw_d         = xw_q;
        y_d          = y_q;
        ld_issued_d  = ld_issued_q;
        mem_rd       = 1'b0;
        mem_addr     = '0;
        iss_fin      = 1'b0;
        iss_wl       = (c_q == C_MAX) && (r_q == R_MAX);
        iss_idx      = IW'(32'(r_q) * 32'(TW_WORDS) + 32'(c_q));

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d      = S_LD_TEMPL;
                    thresh_d     = thresh_i;
                    best_score_d = '1;
                    match_d      = 1'b0;
                    acc_d        = '0;
                    c_d          = '0;
                    r_d          = '0;
                    xw_d         = '0;
                    y_d          = '0;
                    ld_issued_d  = 1'b0;
                end
            end
            S_LD_TEMPL: begin
                if (!ld_issued_q) begin
                    mem_rd   = 1'b1;
                    mem_addr = TEMPL_BASE + 20'(iss_idx);
                    iss_fin  = iss_wl;
                    c_d      = (c_q == C_MAX) ? '0 : c_q + 6'd1;
                    if (c_q == C_MAX) r_d = (r_q == R_MAX) ? '0 : r_q + 9'd1;
                    if (iss_wl) ld_issued_d = 1'b1;
                end
                if (ret_vld && ret_fin) state_d = S_SCAN;
            end
            S_SCAN: begin
                mem_rd   = 1'b1;
                mem_addr = img_addr(IMG_BASE, IMG_WORDS, y_q, r_q, xw_q, c_q);
                iss_fin  = iss_wl && (xw_q == XW_MAX) && (y_q == Y_MAX);
                c_d      = (c_q == C_MAX) ? '0 : c_q + 6'd1;
                if (c_q == C_MAX) r_d = (r_q == R_MAX) ? '0 : r_q + 9'd1;
                if (iss_wl) begin
                    if (xw_q == XW_MAX) begin
                        xw_d = '0;
                        y_d  = y_q + Y_STEP;
                    end else begin
                        xw_d = xw_q + 6'd1;
                    end
                end
                if (iss_fin) state_d = S_DRAIN;
            end
            S_DRAIN: ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Ties keep the earlier window, hence the strict compare.
        if (ret_vld && (state_q == S_SCAN || state_q == S_DRAIN)) begin
            acc_d = sum;
            if (ret_wl) begin
                acc_d = '0;
                if (sum < best_score_q) begin
                    best_score_d = sum;
                    best_x_d     = {ret_xw, 4'b0000};
                    best_y_d     = ret_y;
                end
            end
            if (state_q == S_DRAIN && ret_fin) begin
                state_d = S_DONE;
                match_d = (best_score_d <= thresh_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            thresh_q     <= '0;
            best_score_q <= '1;
            best_x_q     <= '0;
            best_y_q     <= '0;
            match_q      <= 1'b0;
            acc_q        <= '0;
            c_q          <= '0;
            r_q          <= '0;
            xw_q         <= '0;
            y_q          <= '0;
            ld_issued_q  <= 1'b0;
            vld_pipe_q   <= '0;
        end else begin
            state_q      <= state_d;
            thresh_q     <= thresh_d;
            best_score_q <= best_score_d;
            best_x_q     <= best_x_d;
            best_y_q     <= best_y_d;
            match_q      <= match_d;
            acc_q        <= acc_d;
            c_q          <= c_d;
            r_q          <= r_d;
            xw_q         <= xw_d;
            y_q          <= y_d;
            ld_issued_q  <= ld_issued_d;
            vld_pipe_q[0] <= mem_rd;
            for (int i = 1; i < MEM_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
    end

    // Tag payloads and template storage carry no reset; only the valids matter.
    always_ff @(posedge clk_i) begin
        fin_pipe_q[0] <= iss_fin;
        wl_pipe_q[0]  <= iss_wl && (state_q == S_SCAN);
        idx_pipe_q[0] <= iss_idx;
        xw_pipe_q[0]  <= xw_q;
        y_pipe_q[0]   <= y_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            fin_pipe_q[i] <= fin_pipe_q[i-1];
            wl_pipe_q[i]  <= wl_pipe_q[i-1];
            idx_pipe_q[i] <= idx_pipe_q[i-1];
            xw_pipe_q[i]  <= xw_pipe_q[i-1];
            y_pipe_q[i]   <= y_pipe_q[i-1];
        end
        if (!rst_i && state_q == S_LD_TEMPL && ret_vld) templ_q[ret_idx] <= mem_data_i;
    end

    assign mem_rd_o     = mem_rd;
    assign mem_addr_o   = mem_addr;
    assign busy_o       = (state_q == S_LD_TEMPL) || (state_q == S_SCAN) || (state_q == S_DRAIN);
    assign done_o       = (state_q == S_DONE);
    assign best_x_o     = best_x_q;
    assign best_y_o     = best_y_q;
    assign best_score_o = best_score_q;
    assign match_o      = match_q;

endmodule

// File: tb/tb_template_match_scan.sv
// Directed bench: three matcher instances (MEM_LAT 2, 1, 4) share stimulus
// and each sees its own latency-matched SRAM model.
module tb_template_match_scan;

    localparam logic [19:0] TB_BASE = 20'h40000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, start;
    logic [5:0]           thresh;
    logic [15:0][15:0]    img;
    logic [1:0][15:0]     tmpl;

    logic        busy_w [3], done_w [3], rd_w [3], match_w [3];
    logic [19:0] addr_w [3];
    logic [9:0]  bx_w [3];
    logic [8:0]  by_w [3];
    logic [5:0]  bs_w [3];

    int total = 0;
    int bad   = 0;
    int lat_of [3] = '{2, 1, 4};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        logic [19:0] ap [4];
        logic [15:0] data;

        always @(posedge clk) begin
            ap[0] <= addr_w[g];
            for (int i = 1; i < 4; i++) ap[i] <= ap[i-1];
        end
        assign data = (ap[L-1] >= TB_BASE) ? tmpl[ap[L-1][0]] : img[ap[L-1][3:0]];

        template_match_scan #(
            .TEMPL_W(16), .TEMPL_H(2), .IMG_W(64), .IMG_H(4),
            .TEMPL_BASE(TB_BASE), .IMG_BASE(20'h0), .MEM_LAT(L), .STRIDE_Y(1)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .start_i      (start),
            .thresh_i     (thresh),
            .mem_data_i   (data),
            .mem_addr_o   (addr_w[g]),
            .mem_rd_o     (rd_w[g]),
            .busy_o       (busy_w[g]),
            .done_o       (done_w[g]),
            .best_x_o     (bx_w[g]),
            .best_y_o     (by_w[g]),
            .best_score_o (bs_w[g]),
            .match_o      (match_w[g])
        );
    end

    typedef struct {
        logic [15:0][15:0] img;
        logic [5:0]        thr;
        logic [9:0]        ex;
        logic [8:0]        ey;
        logic [5:0]        es;
        logic              em;
        logic              dbl;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Start at cycle 0; outputs sampled on falling edges for 60 cycles.
    task automatic run(input int vi, input bit trace);
        int   dcyc [3];
        int   dcnt [3];
        logic dmatch;
        int   terr, nrd, exp_a;
        bit   exp_rd;
        int   exp_img [$];
        for (int y = 0; y < 3; y++)
            for (int xw = 0; xw < 4; xw++)
                for (int r = 0; r < 2; r++) exp_img.push_back((y + r) * 4 + xw);
        for (int g = 0; g < 3; g++) begin dcyc[g] = -1; dcnt[g] = 0; end
        dmatch = 1'b0; terr = 0; nrd = 0;
        img    = vecs[vi].img;
        thresh = vecs[vi].thr;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start = vecs[vi].dbl && (cyc == 10);
            for (int g = 0; g < 3; g++) begin
                if (done_w[g]) begin
                    dcnt[g]++;
                    if (dcyc[g] < 0) dcyc[g] = cyc;
                    if (g == 0) dmatch = match_w[0];
                end
            end
            if (trace) begin
                exp_rd = (cyc >= 1 && cyc <= 2) || (cyc >= 5 && cyc <= 28);
                exp_a  = (cyc <= 2) ? int'(TB_BASE) + cyc - 1 : ((cyc >= 5 && cyc <= 28) ? exp_img[cyc-5] : 0);
                if (rd_w[0]) nrd++;
                if (rd_w[0] !== exp_rd || (exp_rd && addr_w[0] !== 20'(exp_a)) ||
                    busy_w[0] !== (cyc <= 30)) begin
                    if (terr == 0)
                        $display("FAIL trace cyc %0d: rd=%0b addr=%0h busy=%0b expected rd=%0b addr=%0h",
                                 cyc, rd_w[0], addr_w[0], busy_w[0], exp_rd, exp_a);
                    terr++;
                end
            end
        end
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("v%0d d%0d latency", vi, g), dcyc[g] + 1, 1 + 2 * 13 + 2 * lat_of[g] + 1);
            chk($sformatf("v%0d d%0d done_count", vi, g), dcnt[g], 1);
            chk($sformatf("v%0d d%0d best_x", vi, g), int'(bx_w[g]), int'(vecs[vi].ex));
            chk($sformatf("v%0d d%0d best_y", vi, g), int'(by_w[g]), int'(vecs[vi].ey));
            chk($sformatf("v%0d d%0d best_score", vi, g), int'(bs_w[g]), int'(vecs[vi].es));
            chk($sformatf("v%0d d%0d match", vi, g), int'(match_w[g]), int'(vecs[vi].em));
            chk($sformatf("v%0d d%0d busy_after", vi, g), int'(busy_w[g]), 0);
        end
        chk($sformatf("v%0d match_at_done", vi), int'(dmatch), int'(vecs[vi].em));
        chk($sformatf("v%0d lat4_minus_lat1", vi), dcyc[2] - dcyc[1], 6);
        if (trace) begin
            chk("trace_errors", terr, 0);
            chk("trace_read_count", nrd, 26);
        end
    endtask

    initial begin
        // Template word 0 = FFFF, word 1 = 0000.
        tmpl   = {16'h0000, 16'hFFFF};
        img    = '0;
        rst    = 1'b1;
        start  = 1'b0;
        thresh = '0;

        for (int i = 0; i < 6; i++) begin
            vecs[i].img = '0; vecs[i].dbl = 1'b0;
        end
        vecs[0].img[11] = 16'hFFFF;
        vecs[0].thr = 6'd0;  vecs[0].ex = 10'd48; vecs[0].ey = 9'd2; vecs[0].es = 6'd0;  vecs[0].em = 1'b1;
        vecs[1].thr = 6'd15; vecs[1].ex = 10'd0;  vecs[1].ey = 9'd0; vecs[1].es = 6'd16; vecs[1].em = 1'b0;
        vecs[1].dbl = 1'b1;
        vecs[2].thr = 6'd16; vecs[2].ex = 10'd0;  vecs[2].ey = 9'd0; vecs[2].es = 6'd16; vecs[2].em = 1'b1;
        vecs[3].img[0] = 16'hFFFF;
        vecs[3].thr = 6'd0;  vecs[3].ex = 10'd0;  vecs[3].ey = 9'd0; vecs[3].es = 6'd0;  vecs[3].em = 1'b1;
        vecs[4].img[6] = 16'h00FF; vecs[4].img[10] = 16'h0003;
        vecs[4].thr = 6'd9;  vecs[4].ex = 10'd32; vecs[4].ey = 9'd1; vecs[4].es = 6'd10; vecs[4].em = 1'b0;
        vecs[4].dbl = 1'b1;
        vecs[5].img[5] = 16'hFFFF; vecs[5].img[11] = 16'hFFFF;
        vecs[5].thr = 6'd0;  vecs[5].ex = 10'd16; vecs[5].ey = 9'd1; vecs[5].es = 6'd0;  vecs[5].em = 1'b1;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst busy", int'(busy_w[0]), 0);
        chk("rst done", int'(done_w[0]), 0);
        chk("rst mem_rd", int'(rd_w[0]), 0);
        chk("rst mem_addr", int'(addr_w[0]), 0);
        chk("rst best_x", int'(bx_w[0]), 0);
        chk("rst best_y", int'(by_w[0]), 0);
        chk("rst best_score", int'(bs_w[0]), 63);
        chk("rst match", int'(match_w[0]), 0);

        for (int v = 0; v < 6; v++) run(v, v == 0);

        // Reset pulse in the middle of the scan for every instance.
        img    = vecs[0].img;
        thresh = 6'd0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("midrst d%0d busy", g), int'(busy_w[g]), 0);
            chk($sformatf("midrst d%0d mem_rd", g), int'(rd_w[g]), 0);
            chk($sformatf("midrst d%0d done", g), int'(done_w[g]), 0);
            chk($sformatf("midrst d%0d best_score", g), int'(bs_w[g]), 63);
        end
        @(negedge clk);
        run(0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
